// File: rtl/vec_de_csr_defs.sv
// Shared definitions for the vector configuration (vset*) sequencer:
// FSM states, decoded operation kinds, opcode constants and the decode helper.
`timescale 1ns/1ps
package vec_de_csr_defs;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        COMPUTE,
        WRITE,
        RESP
    } vset_state_e;

    typedef enum logic [1:0] {
        VSETVLI,
        VSETIVLI,
        VSETVL,
        VSET_ILL
    } vset_op_e;

    localparam logic [6:0] OPC_VEC    = 7'h57;
    localparam logic [2:0] FUNCT3_CFG = 3'b111;

    // Observation bundle: FSM state, decoded op of the held instruction, VLMAX.
    typedef struct packed {
        vset_state_e state;
        vset_op_e    op;
        logic [15:0] vlmax;
    } vset_dbg_t;

    function automatic vset_op_e decode_op(input logic [31:0] inst);
        vset_op_e op;
        op = VSET_ILL;
        if (inst[6:0] == OPC_VEC && inst[14:12] == FUNCT3_CFG) begin
            if (!inst[31])                        op = VSETVLI;
            else if (inst[31:30] == 2'b11)        op = VSETIVLI;
            else if (inst[31:25] == 7'b1000000)   op = VSETVL;
            else                                  op = VSET_ILL;
        end
        return op;
    endfunction

endpackage

// File: rtl/vec_vl_calc.sv
// Combinational vl/VLMAX calculator: VLMAX from vtype, vl = min(AVL, VLMAX)
// with the rs1=x0 special cases, plus vtype legality.
`timescale 1ns/1ps
module vec_vl_calc #(
    parameter int XLEN    = 32,
    parameter int VLEN    = 512,
    parameter int VLMAX_W = $clog2(VLEN) + 1
) (
    input  logic [XLEN-1:0]    vtype,
    input  logic [XLEN-1:0]    avl,
    input  logic               rs1_zero,
    input  logic               rd_zero,
    input  logic [XLEN-1:0]    cur_vl,
    output logic [VLMAX_W-1:0] vlmax,
    output logic [XLEN-1:0]    vl,
    output logic               vtype_illegal,
    output logic [7:0]         vtype_bits
);
    localparam logic [VLMAX_W-1:0] VLMAX_E8_M1 = VLMAX_W'(VLEN / 8);

    logic [2:0]      vsew;
    logic [2:0]      vlmul;
    logic [XLEN-1:0] vlmax_x;
    logic [XLEN-1:0] avl_eff;

    assign vsew  = vtype[5:3];
    assign vlmul = vtype[2:0];

    // Only the low two bits steer the shifts; the top bits just flag illegality.
    assign vlmax         = (VLMAX_E8_M1 >> vsew[1:0]) << vlmul[1:0];
    assign vtype_illegal = vsew[2] | vlmul[2] | (|vtype[XLEN-1:8]);
    assign vtype_bits    = vtype[7:0];
    assign vlmax_x       = XLEN'(vlmax);

    always_comb begin
        avl_eff = rs1_zero ? {XLEN{1'b1}} : avl;
        if (rs1_zero && rd_zero) begin
            vl = cur_vl;
        end else begin
            vl = (avl_eff < vlmax_x) ? avl_eff : vlmax_x;
        end
    end

endmodule

// File: rtl/vec_vsetvl_ctrl.sv
// vset* sequencer: accepts one config instruction, waits for the vector pipe
// to drain, computes vl, pulses the regfile write and returns vl for rd.
`timescale 1ns/1ps
module vec_vsetvl_ctrl
    import vec_de_csr_defs::*;
#(
    parameter int XLEN = 32,
    parameter int VLEN = 512
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic [XLEN-1:0] inst,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            inst_valid,
    output logic            inst_ready,
    input  logic            vec_busy,
    input  logic [XLEN-1:0] cur_vl,
    output logic            csrwr_en,
    output logic [XLEN-1:0] vtype_wdata,
    output logic [XLEN-1:0] vl_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_data,
    output logic            illegal,
    output vset_dbg_t       dbg
);
    localparam int VLMAX_W = $clog2(VLEN) + 1;

    // Handshakes: inst is taken on inst_valid && inst_ready (IDLE only);
    // a response is consumed on resp_valid && resp_ready, response fields
    // stay stable from resp_valid rising until that cycle.

    vset_state_e     state_q, state_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    logic [7:0]      vtype_q, vtype_d;
    logic [XLEN-1:0] vl_q, vl_d;
    logic [4:0]      rd_q, rd_d;
    logic            ill_q, ill_d;

    vset_op_e        op;
    logic [XLEN-1:0] vtype_sel;
    logic [XLEN-1:0] avl_sel;
    logic            rs1_zero;
    logic            rd_zero;
    logic [VLMAX_W-1:0] calc_vlmax;
    logic [XLEN-1:0] calc_vl;
    logic            calc_vtype_ill;
    logic [7:0]      calc_vtype_bits;

    assign op = decode_op(inst_q[31:0]);

    always_comb begin
        vtype_sel = rs2_q;
        avl_sel   = rs1_q;
        case (op)
            VSETVLI:  vtype_sel = XLEN'(inst_q[30:20]);
            VSETIVLI: begin
                vtype_sel = XLEN'(inst_q[29:20]);
                avl_sel   = XLEN'(inst_q[19:15]);
            end
            default:  vtype_sel = rs2_q;
        endcase
    end

    // For vsetivli the rs1 field is the immediate, so the x0 rules never apply.
    assign rs1_zero = (op != VSETIVLI) && (inst_q[19:15] == 5'd0);
    assign rd_zero  = (inst_q[11:7] == 5'd0);

    vec_vl_calc #(.XLEN(XLEN), .VLEN(VLEN), .VLMAX_W(VLMAX_W)) u_calc (
        .vtype         (vtype_sel),
        .avl           (avl_sel),
        .rs1_zero      (rs1_zero),
        .rd_zero       (rd_zero),
        .cur_vl        (cur_vl),
        .vlmax         (calc_vlmax),
        .vl            (calc_vl),
        .vtype_illegal (calc_vtype_ill),
        .vtype_bits    (calc_vtype_bits)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            inst_q  <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            vtype_q <= '0;
            vl_q    <= '0;
            rd_q    <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            vtype_q <= vtype_d;
            vl_q    <= vl_d;
            rd_q    <= rd_d;
            ill_q   <= ill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        vtype_d = vtype_q;
        vl_d    = vl_q;
        rd_d    = rd_q;
        ill_d   = ill_q;
        case (state_q)
            IDLE: begin
                if (inst_valid) begin
                    inst_d  = inst;
                    rs1_d   = rs1_data;
                    rs2_d   = rs2_data;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!vec_busy) state_d = COMPUTE;
            end
            COMPUTE: begin
                ill_d = (op == VSET_ILL) || calc_vtype_ill;
                rd_d  = inst_q[11:7];
                if ((op == VSET_ILL) || calc_vtype_ill) begin
                    // Regfile vtype is left untouched; rd gets 0.
                    vl_d    = '0;
                    state_d = RESP;
                end else begin
                    vtype_d = calc_vtype_bits;
                    vl_d    = calc_vl;
                    state_d = WRITE;
                end
            end
            WRITE: state_d = RESP;
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign inst_ready  = (state_q == IDLE);
    assign csrwr_en    = (state_q == WRITE);
    assign resp_valid  = (state_q == RESP);
    assign vtype_wdata = XLEN'(vtype_q);
    assign vl_wdata    = vl_q;
    assign rd_addr     = rd_q;
    assign rd_data     = vl_q;
    assign illegal     = ill_q;

    assign dbg.state = state_q;
    assign dbg.op    = op;
    assign dbg.vlmax = 16'(calc_vlmax);

endmodule

// File: tb/tb_vec_vsetvl_ctrl.sv
// Directed bench for vec_vsetvl_ctrl: legal/illegal vset* forms, latency,
// drain stalls, response back-pressure and mid-flight resets.
`timescale 1ns/1ps
module tb_vec_vsetvl_ctrl;
    import vec_de_csr_defs::*;

    logic        clk;
    logic        n_rst;
    logic [31:0] inst;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        inst_valid;
    logic        inst_ready;
    logic        vec_busy;
    logic [31:0] cur_vl;
    logic        csrwr_en;
    logic [31:0] vtype_wdata;
    logic [31:0] vl_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        illegal;
    vset_dbg_t   dbg;

    int checks = 0;
    int errors = 0;

    vec_vsetvl_ctrl #(.XLEN(32), .VLEN(512)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .inst        (inst),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .vec_busy    (vec_busy),
        .cur_vl      (cur_vl),
        .csrwr_en    (csrwr_en),
        .vtype_wdata (vtype_wdata),
        .vl_wdata    (vl_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .illegal     (illegal),
        .dbg         (dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_vsetvli(input logic [4:0] rd, input logic [4:0] rs1,
                                                input logic [10:0] zimm);
        return {1'b0, zimm, rs1, 3'b111, rd, 7'h57};
    endfunction

    function automatic logic [31:0] enc_vsetivli(input logic [4:0] rd, input logic [4:0] uimm,
                                                 input logic [9:0] zimm);
        return {2'b11, zimm, uimm, 3'b111, rd, 7'h57};
    endfunction

    function automatic logic [31:0] enc_vsetvl(input logic [4:0] rd, input logic [4:0] rs1,
                                               input logic [4:0] rs2);
        return {7'b1000000, rs2, rs1, 3'b111, rd, 7'h57};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, ":inst_ready"}, 32'(inst_ready), 32'd1);
        check({tag, ":csrwr_en"}, 32'(csrwr_en), 32'd0);
        check({tag, ":resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, ":vtype_wdata"}, vtype_wdata, 32'd0);
        check({tag, ":vl_wdata"}, vl_wdata, 32'd0);
        check({tag, ":rd_addr"}, 32'(rd_addr), 32'd0);
        check({tag, ":rd_data"}, rd_data, 32'd0);
        check({tag, ":illegal"}, 32'(illegal), 32'd0);
        check({tag, ":state"}, 32'(dbg.state), 32'(IDLE));
    endtask

    // Offers one instruction in IDLE; returns at the negedge of cycle 1.
    task automatic accept(input string tag, input logic [31:0] w, input logic [31:0] r1,
                          input logic [31:0] r2);
        @(negedge clk);
        check({tag, ":inst_ready"}, 32'(inst_ready), 32'd1);
        inst       = w;
        rs1_data   = r1;
        rs2_data   = r2;
        inst_valid = 1'b1;
        @(negedge clk);
        inst_valid = 1'b0;
    endtask

    task automatic run(input string tag, input logic [31:0] w, input logic [31:0] r1,
                       input logic [31:0] r2, input int busy, input int hold,
                       input logic ill, input logic [7:0] exp_vtype, input logic [31:0] exp_vl);
        int n;
        logic [31:0] exp_rd;
        exp_rd = ill ? 32'd0 : exp_vl;
        accept(tag, w, r1, r2);
        n = 1;
        vec_busy = (busy > 0);
        for (int i = 0; i < busy; i++) begin
            @(negedge clk);
            n++;
            check({tag, ":busy_no_wr"}, 32'(csrwr_en), 32'd0);
        end
        vec_busy = 1'b0;
        while (!(csrwr_en || resp_valid) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, ":latency"}, 32'(n), 32'(3 + busy));
        if (ill) begin
            check({tag, ":no_wr"}, 32'(csrwr_en), 32'd0);
            check({tag, ":resp_valid"}, 32'(resp_valid), 32'd1);
        end else begin
            check({tag, ":csrwr_en"}, 32'(csrwr_en), 32'd1);
            check({tag, ":vtype_wdata"}, vtype_wdata, {24'd0, exp_vtype});
            check({tag, ":vl_wdata"}, vl_wdata, exp_vl);
            vec_busy = 1'b1;
            @(negedge clk);
            vec_busy = 1'b0;
            check({tag, ":wr_one_cycle"}, 32'(csrwr_en), 32'd0);
            check({tag, ":resp_valid"}, 32'(resp_valid), 32'd1);
        end
        check({tag, ":rd_addr"}, 32'(rd_addr), 32'(w[11:7]));
        check({tag, ":rd_data"}, rd_data, exp_rd);
        check({tag, ":illegal"}, 32'(illegal), 32'(ill));
        for (int i = 0; i < hold; i++) begin
            inst_valid = 1'b1;
            resp_ready = 1'b0;
            @(negedge clk);
            check({tag, ":hold_valid"}, 32'(resp_valid), 32'd1);
            check({tag, ":hold_not_ready"}, 32'(inst_ready), 32'd0);
            check({tag, ":hold_rd_data"}, rd_data, exp_rd);
            check({tag, ":hold_rd_addr"}, 32'(rd_addr), 32'(w[11:7]));
            check({tag, ":hold_illegal"}, 32'(illegal), 32'(ill));
        end
        inst_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check({tag, ":done_valid"}, 32'(resp_valid), 32'd0);
        check({tag, ":done_ready"}, 32'(inst_ready), 32'd1);
    endtask

    // Watches a quiet window after a reset: no write strobe, no response.
    task automatic quiet_window(input string tag);
        logic seen;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (csrwr_en || resp_valid) seen = 1'b1;
        end
        check({tag, ":no_activity"}, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        n_rst      = 1'b0;
        inst       = '0;
        rs1_data   = '0;
        rs2_data   = '0;
        inst_valid = 1'b0;
        vec_busy   = 1'b0;
        cur_vl     = 32'd7;
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        n_rst = 1'b1;

        run("vli_e32m2", enc_vsetvli(5'd10, 5'd5, 11'h011), 32'd100, 32'd0, 0, 0, 1'b0, 8'h11, 32'd32);
        run("ivli_u5", enc_vsetivli(5'd7, 5'd5, 10'h000), 32'hdead, 32'd0, 0, 0, 1'b0, 8'h00, 32'd5);
        run("vl_db", enc_vsetvl(5'd1, 5'd2, 5'd3), 32'd0, 32'h0000_00db, 0, 0, 1'b0, 8'hdb, 32'd0);
        run("rs1z_rd3", enc_vsetvli(5'd3, 5'd0, 11'h009), 32'd55, 32'd0, 0, 0, 1'b0, 8'h09, 32'd64);
        run("rs1z_rd0", enc_vsetvli(5'd0, 5'd0, 11'h000), 32'd55, 32'd0, 0, 0, 1'b0, 8'h00, 32'd7);
        run("ivli_clip", enc_vsetivli(5'd9, 5'd31, 10'h018), 32'd0, 32'd0, 0, 0, 1'b0, 8'h18, 32'd8);
        run("full_cmp", enc_vsetvli(5'd4, 5'd6, 11'h000), 32'h0001_0005, 32'd0, 0, 0, 1'b0, 8'h00, 32'd64);
        run("e8m8_max", enc_vsetvli(5'd4, 5'd6, 11'h003), 32'hffff_ffff, 32'd0, 0, 0, 1'b0, 8'h03, 32'd512);

        run("ill_sew", enc_vsetvli(5'd4, 5'd6, 11'h020), 32'd10, 32'd0, 0, 0, 1'b1, 8'h00, 32'd0);
        run("ill_lmul", enc_vsetvli(5'd4, 5'd6, 11'h004), 32'd10, 32'd0, 0, 0, 1'b1, 8'h00, 32'd0);
        run("ill_vli_hi", enc_vsetvli(5'd4, 5'd6, 11'h100), 32'd10, 32'd0, 0, 0, 1'b1, 8'h00, 32'd0);
        run("ill_vl_b31", enc_vsetvl(5'd5, 5'd6, 5'd7), 32'd10, 32'h8000_0011, 0, 0, 1'b1, 8'h00, 32'd0);
        w = enc_vsetvli(5'd4, 5'd6, 11'h011);
        w[6:0] = 7'h33;
        run("ill_opc", w, 32'd10, 32'd0, 0, 0, 1'b1, 8'h00, 32'd0);
        w = enc_vsetvl(5'd4, 5'd6, 5'd7);
        w[25] = 1'b1;
        run("ill_funct", w, 32'd10, 32'd0, 0, 0, 1'b1, 8'h00, 32'd0);

        run("busy_hold", enc_vsetvli(5'd12, 5'd7, 11'h003), 32'd300, 32'd0, 10, 5, 1'b0, 8'h03, 32'd300);
        run("ill_busy", enc_vsetvli(5'd13, 5'd7, 11'h020), 32'd300, 32'd0, 3, 2, 1'b1, 8'h00, 32'd0);

        // Reset pulsed while draining.
        accept("rst_drain", enc_vsetvli(5'd8, 5'd5, 11'h011), 32'd20, 32'd0);
        vec_busy = 1'b1;
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        check_reset_outputs("rst_drain");
        @(negedge clk);
        n_rst    = 1'b1;
        vec_busy = 1'b0;
        quiet_window("rst_drain");
        run("after_rst_drain", enc_vsetvli(5'd8, 5'd5, 11'h011), 32'd20, 32'd0, 0, 0, 1'b0, 8'h11, 32'd20);

        // Reset pulsed in the write cycle.
        accept("rst_write", enc_vsetvli(5'd9, 5'd5, 11'h000), 32'd40, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("rst_write:pre_wr", 32'(csrwr_en), 32'd1);
        n_rst = 1'b0;
        #1;
        check_reset_outputs("rst_write");
        @(negedge clk);
        n_rst = 1'b1;
        quiet_window("rst_write");
        run("after_rst_write", enc_vsetivli(5'd11, 5'd17, 10'h008), 32'd0, 32'd0, 0, 1, 1'b0, 8'h08, 32'd17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
